pe_mac_row: RTL and testbench
=============================

Name: pe_mac_row

Overview:
- Downstream consumer of the weight fetch stage's pe_data_in bus: one row of P weight lanes, each a signed multiply-accumulate.
- Each lane accumulates weight × activation over a vector of up to 2^FEATURE_BITS beats.
- After the vector completes, the P accumulator results are serialized out one per beat on a valid/ready interface.
- Sits between the weight fetch stage and the result/activation-function logic of the LSTM accelerator.

Parameters:
- FEATURE_BITS, 4, vector length field width; max vector length 2^FEATURE_BITS.
- ELEMENT_BITS, 8, width of each signed weight/activation element.
- P, 4, number of lanes, matching the weight fetch stage's output bus.
- ACC_BITS, 2*ELEMENT_BITS+FEATURE_BITS, accumulator and result width; derived, not overridden.

Ports:
- sys_clk  input  1  single clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a vector; honoured only in IDLE.
- vec_len  input  FEATURE_BITS  vector length minus 1, sampled on an accepted start.
- pe_data_in  input  P*ELEMENT_BITS  signed weights; lane k = bits [k*ELEMENT_BITS +: ELEMENT_BITS].
- act_in  input  ELEMENT_BITS  signed activation, broadcast to all lanes.
- in_valid  input  1  pe_data_in and act_in form a valid beat.
- in_ready  output  1  row accepts a beat; high only in ACCUM.
- res_data  output  ACC_BITS  signed result of lane res_idx.
- res_idx  output  $clog2(P)  lane index of res_data.
- res_valid  output  1  res_data is valid.
- res_ready  input  1  downstream accepts res_data.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle pulse after the last result is accepted.

Behaviour:
- Reset (asynchronous, any state, including mid-vector):
  - state forced to IDLE.
  - All accumulators, beat counter and res_idx cleared to 0.
  - in_ready, res_valid, busy and done are 0; res_data reads 0.
- FSM states: IDLE, ACCUM, OUT.
- IDLE:
  - in_ready=0, res_valid=0.
  - start=1 → latch vec_len, clear all accumulators and the beat counter, go to ACCUM next cycle.
  - A beat presented in the same cycle as start is not accepted.
- ACCUM:
  - in_ready=1. A beat is accepted when in_valid&&in_ready.
  - Each accepted beat updates every lane k: acc[k] += sext(w_k)*sext(act_in), a full-precision signed product.
  - in_valid gaps: accumulators and counter hold.
  - When the accepted beat is number vec_len+1, go to OUT next cycle with res_idx=0.
  - No overflow is possible: ACC_BITS covers 2^FEATURE_BITS products of (-2^(E-1))^2.
- OUT:
  - res_valid=1; res_data = acc[res_idx], combinational mux from registers.
  - First result is valid the cycle after the final beat is accepted and includes that beat.
  - res_valid&&res_ready with res_idx<P-1 → res_idx increments.
  - Handshake with res_idx==P-1 → go to IDLE; done=1 for exactly the next cycle (state already IDLE there).
  - res_ready low: res_data and res_idx hold stable; res_valid stays high (no retraction).
- start outside IDLE: ignored; no state change, vec_len not re-latched.
- start may be accepted in the same cycle done is high (state is IDLE).
- busy = (state != IDLE).

Optional Feature:
- Macro PE_MAC_SAT_EN.
- Defined: res_data is acc[res_idx] clamped to [-2^(ELEMENT_BITS-1), 2^(ELEMENT_BITS-1)-1], then sign-extended to ACC_BITS. Accumulators themselves stay full precision.
- Undefined: res_data is the raw accumulator; no clamp logic is synthesized.

Decomposition:
- Shared package sa_pkg holds:
  - ELEMENT_BITS, FEATURE_BITS, P defaults.
  - ACC_BITS derivation function.
  - FSM state enum typedef mac_state_t.
- Sub-module pe_mac: one lane = signed multiplier + accumulator register, with clear and enable inputs. Instantiated P times via generate.
- FSM, beat counter and output serializer live in pe_mac_row.

Test Plan:
- Basic vector: vec_len=2; beats act=1,2,3; lanes w=1,2,3,4 on every beat → results 6,12,18,24 on res_idx 0..3 over 4 consecutive cycles (res_ready=1), then done pulse; busy falls with done.
- Backpressure: same vector, res_ready low 5 cycles at res_idx=0 → res_valid stays 1 and res_data stays 6 throughout; remaining results follow once res_ready rises.
- Signed extreme: vec_len=15; all w=0x80, act=0x80 → every lane 262144 without PE_MAC_SAT_EN, 127 with it.
- Input gaps: vec_len=3; in_valid toggled 1,0,0,1,1,0,1; act=2, w=1 → OUT entered after the 4th accepted beat; every lane 8.
- Reset mid-ACCUM: reset_n asserted after 2 of 4 beats → outputs 0 immediately. A new start with vec_len=0, act=5, w=3 → every lane 15 (no residue from the aborted vector).
- Start while busy: pulse start with vec_len=0 during ACCUM and during OUT → ignored; the original vector length is honoured and its results are unchanged.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array row: default sizes, accumulator
// width derivation and the MAC row FSM state type.
package sa_pkg;

   localparam int SA_FEATURE_BITS = 4;
   localparam int SA_ELEMENT_BITS = 8;
   localparam int SA_P            = 4;

   // Wide enough for 2^feature_bits products of two most-negative elements.
   function automatic int calc_acc_bits(input int element_bits, input int feature_bits);
      return 2 * element_bits + feature_bits;
   endfunction

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      OUT   = 2'd2
   } mac_state_t;

endpackage

// File: rtl/pe_mac.sv
// One weight lane: signed ELEMENT_BITS x ELEMENT_BITS multiplier feeding a
// full-precision accumulator with synchronous clear and enable.
module pe_mac
   import sa_pkg::*;
#(
   parameter int  ELEMENT_BITS = SA_ELEMENT_BITS,
   parameter int  FEATURE_BITS = SA_FEATURE_BITS,
   localparam int ACC_BITS     = calc_acc_bits(ELEMENT_BITS, FEATURE_BITS)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr_i,
   input  logic                    en_i,
   input  logic [ELEMENT_BITS-1:0] weight_i,
   input  logic [ELEMENT_BITS-1:0] act_i,
   output logic [ACC_BITS-1:0]     acc_o
);

   logic signed [2*ELEMENT_BITS-1:0] prod;
   logic signed [ACC_BITS-1:0]       acc_q;
   logic signed [ACC_BITS-1:0]       acc_d;

   assign prod = $signed(weight_i) * $signed(act_i);

   always_comb begin
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (en_i) begin
         acc_d = acc_q + ACC_BITS'(prod);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/pe_mac_row.sv
// Row of P signed MAC lanes: accumulates a vector of beats, then serializes
// one result per lane. Define PE_MAC_SAT_EN to clamp results to element range.
module pe_mac_row
   import sa_pkg::*;
#(
   parameter int  FEATURE_BITS = SA_FEATURE_BITS,
   parameter int  ELEMENT_BITS = SA_ELEMENT_BITS,
   parameter int  P            = SA_P,
   localparam int ACC_BITS     = calc_acc_bits(ELEMENT_BITS, FEATURE_BITS),
   localparam int IDX_BITS     = (P > 1) ? $clog2(P) : 1
) (
   input  logic                      sys_clk,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic [FEATURE_BITS-1:0]   vec_len,
   input  logic [P*ELEMENT_BITS-1:0] pe_data_in,
   input  logic [ELEMENT_BITS-1:0]   act_in,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [ACC_BITS-1:0]       res_data,
   output logic [IDX_BITS-1:0]       res_idx,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic                      busy,
   output logic                      done
);

   mac_state_t                state_q, state_d;
   logic [FEATURE_BITS-1:0]   cnt_q, cnt_d;
   logic [FEATURE_BITS-1:0]   len_q, len_d;
   logic [IDX_BITS-1:0]       idx_q, idx_d;
   logic                      done_q, done_d;
   logic                      clr;
   logic                      beat;
   logic [ACC_BITS-1:0]       acc [P];
   logic signed [ACC_BITS-1:0] sel;
   logic signed [ACC_BITS-1:0] out_val;

   assign in_ready  = (state_q == ACCUM);
   assign res_valid = (state_q == OUT);
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign res_idx   = idx_q;
   assign beat      = in_valid && in_ready;

   for (genvar gi = 0; gi < P; gi++) begin : g_lane
      pe_mac #(
         .ELEMENT_BITS(ELEMENT_BITS),
         .FEATURE_BITS(FEATURE_BITS)
      ) u_mac (
         .clk     (sys_clk),
         .rst_n   (reset_n),
         .clr_i   (clr),
         .en_i    (beat),
         .weight_i(pe_data_in[gi*ELEMENT_BITS +: ELEMENT_BITS]),
         .act_i   (act_in),
         .acc_o   (acc[gi])
      );
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      clr     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               len_d   = vec_len;
               cnt_d   = '0;
               clr     = 1'b1;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (beat) begin
               if (cnt_q == len_q) begin
                  cnt_d   = '0;
                  idx_d   = '0;
                  state_d = OUT;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         OUT: begin
            if (res_ready) begin
               if (idx_q == IDX_BITS'(P - 1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
      end
   end

   assign sel = $signed(acc[idx_q]);

`ifdef PE_MAC_SAT_EN
   localparam logic signed [ACC_BITS-1:0] SAT_MAX = ACC_BITS'((2 ** (ELEMENT_BITS - 1)) - 1);
   localparam logic signed [ACC_BITS-1:0] SAT_MIN = ACC_BITS'(-(2 ** (ELEMENT_BITS - 1)));

   always_comb begin
      out_val = sel;
      if (sel > SAT_MAX) begin
         out_val = SAT_MAX;
      end else if (sel < SAT_MIN) begin
         out_val = SAT_MIN;
      end
   end
`else
   assign out_val = sel;
`endif

   // Result bus is forced to zero whenever no result is being offered.
   assign res_data = res_valid ? out_val : '0;

endmodule

// File: tb/tb_pe_mac_row.sv
// Self-checking bench for pe_mac_row: directed vectors, a queue of expected
// lane results, and immediate assertions at every comparison.
module tb_pe_mac_row;

   localparam int F    = 4;
   localparam int E    = 8;
   localparam int P    = 4;
   localparam int ACC  = 2 * E + F;
   localparam int IDXB = 2;

   logic             sys_clk;
   logic             reset_n;
   logic             start;
   logic [F-1:0]     vec_len;
   logic [P*E-1:0]   pe_data_in;
   logic [E-1:0]     act_in;
   logic             in_valid;
   logic             in_ready;
   logic [ACC-1:0]   res_data;
   logic [IDXB-1:0]  res_idx;
   logic             res_valid;
   logic             res_ready;
   logic             busy;
   logic             done;

   int checks   = 0;
   int failures = 0;
   int expData[$];
   int expIdx[$];
   int wv[P];
   int av[16];
   int gv[16];

   pe_mac_row #(
      .FEATURE_BITS(F),
      .ELEMENT_BITS(E),
      .P(P)
   ) dut (
      .sys_clk   (sys_clk),
      .reset_n   (reset_n),
      .start     (start),
      .vec_len   (vec_len),
      .pe_data_in(pe_data_in),
      .act_in    (act_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .res_data  (res_data),
      .res_idx   (res_idx),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .busy      (busy),
      .done      (done)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int satModel(input int v);
`ifdef PE_MAC_SAT_EN
      if (v > 127) return 127;
      if (v < -128) return -128;
`endif
      return v;
   endfunction

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic driveWeights();
      for (int k = 0; k < P; k++) begin
         pe_data_in[k*E +: E] = E'(wv[k]);
      end
   endtask

   // Runs one vector using wv/av/gv and pushes the model's lane results.
   task automatic applyStimulus(input int len, input bit pokeStart);
      int sum[P];
      for (int k = 0; k < P; k++) sum[k] = 0;
      checkOutput("idle_in_ready", int'(in_ready), 0);
      driveWeights();
      start    = 1'b1;
      vec_len  = F'(len);
      in_valid = 1'b1;
      act_in   = 8'h7f;
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
      checkOutput("accum_busy", int'(busy), 1);
      checkOutput("accum_in_ready", int'(in_ready), 1);
      for (int b = 0; b <= len; b++) begin
         for (int g = 0; g < gv[b]; g++) begin
            in_valid = 1'b0;
            act_in   = 8'h55;
            tick();
         end
         in_valid = 1'b1;
         act_in   = E'(av[b]);
         if (pokeStart && b == 0) begin
            start   = 1'b1;
            vec_len = '0;
         end
         tick();
         start = 1'b0;
         for (int k = 0; k < P; k++) sum[k] += wv[k] * av[b];
      end
      in_valid = 1'b0;
      for (int k = 0; k < P; k++) begin
         expData.push_back(satModel(sum[k]));
         expIdx.push_back(k);
      end
   endtask

   task automatic drainResults(input int stall, input bit pokeStart);
      int n;
      n = expData.size();
      checkOutput("queue_depth", n, P);
      res_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
         checkOutput("stall_valid", int'(res_valid), 1);
         checkOutput("stall_idx", int'(res_idx), expIdx[0]);
         checkOutput("stall_data", int'($signed(res_data)), expData[0]);
         tick();
      end
      res_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         checkOutput("res_valid", int'(res_valid), 1);
         checkOutput("res_idx", int'(res_idx), expIdx[0]);
         checkOutput("res_data", int'($signed(res_data)), expData[0]);
         if (pokeStart && i == 0) begin
            start   = 1'b1;
            vec_len = '0;
         end
         void'(expData.pop_front());
         void'(expIdx.pop_front());
         tick();
         start = 1'b0;
         if (i < n - 1) checkOutput("done_early", int'(done), 0);
      end
      res_ready = 1'b0;
      checkOutput("done_pulse", int'(done), 1);
      checkOutput("busy_after", int'(busy), 0);
      tick();
      checkOutput("done_clear", int'(done), 0);
      checkOutput("res_valid_idle", int'(res_valid), 0);
   endtask

   initial begin
      reset_n    = 1'b0;
      start      = 1'b0;
      vec_len    = '0;
      pe_data_in = '0;
      act_in     = '0;
      in_valid   = 1'b0;
      res_ready  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         av[i] = 0;
         gv[i] = 0;
      end
      repeat (2) @(posedge sys_clk);
      #1;
      checkOutput("rst_in_ready", int'(in_ready), 0);
      checkOutput("rst_res_valid", int'(res_valid), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_done", int'(done), 0);
      checkOutput("rst_res_data", int'(res_data), 0);
      checkOutput("rst_res_idx", int'(res_idx), 0);
      reset_n = 1'b1;
      tick();

      $display("[TB] basic vector");
      wv = '{1, 2, 3, 4};
      av[0] = 1; av[1] = 2; av[2] = 3;
      applyStimulus(2, 1'b0);
      drainResults(0, 1'b0);

      $display("[TB] backpressure");
      applyStimulus(2, 1'b0);
      drainResults(5, 1'b0);

      $display("[TB] signed extreme");
      wv = '{-128, -128, -128, -128};
      for (int i = 0; i < 16; i++) av[i] = -128;
      applyStimulus(15, 1'b0);
      drainResults(0, 1'b0);

      $display("[TB] input gaps");
      wv = '{1, 1, 1, 1};
      for (int i = 0; i < 16; i++) av[i] = 2;
      gv[1] = 2; gv[3] = 1;
      applyStimulus(3, 1'b0);
      drainResults(0, 1'b0);
      for (int i = 0; i < 16; i++) gv[i] = 0;

      $display("[TB] reset mid-accumulate");
      wv = '{7, 7, 7, 7};
      driveWeights();
      start   = 1'b1;
      vec_len = F'(3);
      tick();
      start    = 1'b0;
      in_valid = 1'b1;
      act_in   = 8'd4;
      tick();
      tick();
      in_valid = 1'b0;
      reset_n  = 1'b0;
      #1;
      checkOutput("arst_in_ready", int'(in_ready), 0);
      checkOutput("arst_busy", int'(busy), 0);
      checkOutput("arst_res_valid", int'(res_valid), 0);
      checkOutput("arst_res_data", int'(res_data), 0);
      checkOutput("arst_done", int'(done), 0);
      tick();
      reset_n = 1'b1;
      tick();
      wv = '{3, 3, 3, 3};
      av[0] = 5;
      applyStimulus(0, 1'b0);
      drainResults(0, 1'b0);

      $display("[TB] start while busy");
      wv = '{1, 2, 3, 4};
      av[0] = 1; av[1] = 2; av[2] = 3;
      applyStimulus(2, 1'b1);
      drainResults(0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
